// File: rtl/pwm_gate_drive.sv
// pwm_gate_drive: complementary gate pair with programmable period, duty and
// dead-time. New settings land in a shadow register and are promoted to the
// active set only at a period boundary (or while idle).
//
// state | meaning
// IDLE  | stopped, count held at 0, gates low, shadow loads immediately
// RUN   | counting 0..P and wrapping, gates decoded from count
// DRAIN | run request dropped; finish the current period, then go IDLE
module pwm_gate_drive #(
  parameter int COUNT_BITS = 5,
  parameter int DEAD_BITS  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [COUNT_BITS-1:0] cfg_period,
  input  logic [COUNT_BITS:0]   cfg_duty,
  input  logic [DEAD_BITS-1:0]  cfg_dead,
  output logic                  ctrl_hi,
  output logic                  ctrl_lo,
  output logic                  period_start
);

  // Compare width leaves headroom for duty + dead-time without overflow.
  localparam int CW = ((DEAD_BITS > COUNT_BITS) ? DEAD_BITS : COUNT_BITS) + 2;
  localparam logic [COUNT_BITS:0] DUTY_RST = {2'b01, {(COUNT_BITS-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [COUNT_BITS-1:0] count_q, count_d;

  logic [COUNT_BITS-1:0] period_q;
  logic [COUNT_BITS:0]   duty_q;
  logic [DEAD_BITS-1:0]  dead_q;

  logic [COUNT_BITS-1:0] sh_period_q;
  logic [COUNT_BITS:0]   sh_duty_q;
  logic [DEAD_BITS-1:0]  sh_dead_q;
  logic                  sh_full_q;

  logic                  hi_q, lo_q, start_q;
  logic                  hi_d, lo_d, start_d;

  logic                  at_end;
  logic                  accept;
  logic                  load;

  logic [CW-1:0]         c_ext, d_ext, dt_ext;
  logic                  raw;

  assign at_end    = (count_q == period_q);
  assign cfg_ready = !sh_full_q;
  assign accept    = cfg_valid && !sh_full_q;
  // DRAIN shares the RUN boundary so a re-enable mid-drain still switches
  // settings cleanly on a wrap.
  assign load      = sh_full_q && ((state_q == S_IDLE) || at_end);

  // State and period counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next state and next count.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        count_d = '0;
        if (en) state_d = S_RUN;
      end
      S_RUN: begin
        count_d = at_end ? '0 : count_q + COUNT_BITS'(1);
        if (!en) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        count_d = at_end ? '0 : count_q + COUNT_BITS'(1);
        if (en)          state_d = S_RUN;
        else if (at_end) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase
  end

  // Gate decode from the current count and active settings.
  always_comb begin
    c_ext   = CW'(count_q);
    d_ext   = CW'(duty_q);
    dt_ext  = CW'(dead_q);
    raw     = (c_ext < d_ext);
    hi_d    = 1'b0;
    lo_d    = 1'b0;
    start_d = 1'b0;
    if (state_q != S_IDLE) begin
      hi_d    = raw && (c_ext >= dt_ext);
      lo_d    = !raw && (c_ext >= (d_ext + dt_ext));
      start_d = (count_q == '0);
    end
  end

  // Registered gate outputs, one cycle behind the count they decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
      start_q <= 1'b0;
    end else begin
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      start_q <= start_d;
    end
  end

  assign ctrl_hi      = hi_q;
  assign ctrl_lo      = lo_q;
  assign period_start = start_q;

  // Shadow register: captures a handshake, empties when promoted.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_full_q   <= 1'b0;
      sh_period_q <= '0;
      sh_duty_q   <= '0;
      sh_dead_q   <= '0;
    end else if (accept) begin
      sh_full_q   <= 1'b1;
      sh_period_q <= cfg_period;
      sh_duty_q   <= cfg_duty;
      sh_dead_q   <= cfg_dead;
    end else if (load) begin
      sh_full_q   <= 1'b0;
    end
  end

  // Active settings; defaults give the legacy 32-cycle 50% square wave.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_q <= '1;
      duty_q   <= DUTY_RST;
      dead_q   <= '0;
    end else if (load) begin
      period_q <= sh_period_q;
      duty_q   <= sh_duty_q;
      dead_q   <= sh_dead_q;
    end
  end

endmodule

// File: tb/tb_pwm_gate_drive.sv
// Bench for pwm_gate_drive: expected {cfg_ready, ctrl_hi, ctrl_lo,
// period_start} per cycle are queued as stimulus is planned and popped as the
// DUT produces each output cycle.
module tb_pwm_gate_drive;

  logic       clk = 1'b0;
  logic       rst, en, cfg_valid, cfg_ready;
  logic [4:0] cfg_period;
  logic [5:0] cfg_duty;
  logic [2:0] cfg_dead;
  logic       ctrl_hi, ctrl_lo, period_start;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic rdy;
    logic hi;
    logic lo;
    logic st;
  } exp_t;

  typedef struct {
    int p;
    int d;
    int dt;
  } cfg_t;

  exp_t q[$];
  localparam exp_t ZERO_RDY = 4'b1000;

  always #5 clk = ~clk;

  pwm_gate_drive #(.COUNT_BITS(5), .DEAD_BITS(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_period   (cfg_period),
    .cfg_duty     (cfg_duty),
    .cfg_dead     (cfg_dead),
    .ctrl_hi      (ctrl_hi),
    .ctrl_lo      (ctrl_lo),
    .period_start (period_start)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t dec(int c, cfg_t k, logic rdy);
    exp_t e;
    e.rdy = rdy;
    e.hi  = (c < k.d) && (c >= k.dt);
    e.lo  = (c >= k.d) && (c >= k.d + k.dt);
    e.st  = (c == 0);
    return e;
  endfunction

  task automatic send(cfg_t k);
    cfg_valid  = 1'b1;
    cfg_period = 5'(k.p);
    cfg_duty   = 6'(k.d);
    cfg_dead   = 3'(k.dt);
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0;
    cfg_period = '0; cfg_duty = '0; cfg_dead = '0;
    tick; tick;
    checks++;
    if ({cfg_ready, ctrl_hi, ctrl_lo, period_start} !== 4'b1000) begin
      errors++;
      $display("FAIL reset got=%b exp=1000", {cfg_ready, ctrl_hi, ctrl_lo, period_start});
    end
    rst = 1'b0;
    tick;
    checks++;
    if ({cfg_ready, ctrl_hi, ctrl_lo, period_start} !== 4'b1000) begin
      errors++;
      $display("FAIL idle_after_reset got=%b exp=1000", {cfg_ready, ctrl_hi, ctrl_lo, period_start});
    end
  endtask

  task automatic test_defaults;
    cfg_t def = '{31, 16, 0};
    exp_t e;
    int i = 0;
    en = 1'b1;
    tick;
    checks++;
    if ({cfg_ready, ctrl_hi, ctrl_lo, period_start} !== 4'b1000) begin
      errors++;
      $display("FAIL first_run_cycle got=%b exp=1000", {cfg_ready, ctrl_hi, ctrl_lo, period_start});
    end
    tick;
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < 32; c++) q.push_back(dec(c, def, 1'b1));
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({cfg_ready, ctrl_hi, ctrl_lo, period_start} !== e) begin
        errors++;
        $display("FAIL defaults i=%0d got=%b exp=%b", i, {cfg_ready, ctrl_hi, ctrl_lo, period_start}, e);
      end
      checks++;
      if (ctrl_hi && ctrl_lo) begin
        errors++;
        $display("FAIL overlap i=%0d got hi=1 lo=1 exp not both", i);
      end
      i++;
      tick;
    end
  endtask

  task automatic test_mid_reconfig;
    cfg_t def = '{31, 16, 0};
    cfg_t nw  = '{9, 3, 1};
    exp_t e;
    int i = 0;
    for (int c = 0; c < 32; c++) q.push_back(dec(c, def, !(c >= 5 && c <= 30)));
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < 10; c++) q.push_back(dec(c, nw, 1'b1));
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({cfg_ready, ctrl_hi, ctrl_lo, period_start} !== e) begin
        errors++;
        $display("FAIL mid_reconfig i=%0d got=%b exp=%b", i, {cfg_ready, ctrl_hi, ctrl_lo, period_start}, e);
      end
      if (i == 4) send(nw);
      if (i == 5) cfg_valid = 1'b0;
      i++;
      tick;
    end
  endtask

  task automatic test_back_to_back;
    cfg_t x = '{9, 3, 1};
    cfg_t a = '{7, 4, 0};
    cfg_t b = '{5, 2, 1};
    exp_t e;
    int i = 0;
    for (int c = 0; c < 10; c++) q.push_back(dec(c, x, (c == 0) || (c == 9)));
    for (int c = 0; c < 8; c++)  q.push_back(dec(c, a, c == 7));
    for (int c = 0; c < 6; c++)  q.push_back(dec(c, b, 1'b1));
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({cfg_ready, ctrl_hi, ctrl_lo, period_start} !== e) begin
        errors++;
        $display("FAIL back_to_back i=%0d got=%b exp=%b", i, {cfg_ready, ctrl_hi, ctrl_lo, period_start}, e);
      end
      if (i == 0)  send(a);
      if (i == 1)  send(b);
      if (i == 10) cfg_valid = 1'b0;
      i++;
      tick;
    end
  endtask

  task automatic test_boundaries;
    cfg_t list[4];
    cfg_t cur = '{5, 2, 1};
    exp_t e;
    list[0] = '{7, 0, 2};
    list[1] = '{7, 8, 0};
    list[2] = '{7, 3, 3};
    list[3] = '{31, 16, 0};
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c <= cur.p; c++) q.push_back(dec(c, cur, (c == 0) || (c == cur.p)));
      for (int c = 0; q.size() > 0; c++) begin
        e = q.pop_front();
        checks++;
        if ({cfg_ready, ctrl_hi, ctrl_lo, period_start} !== e) begin
          errors++;
          $display("FAIL boundary k=%0d c=%0d got=%b exp=%b", k, c, {cfg_ready, ctrl_hi, ctrl_lo, period_start}, e);
        end
        if (c == 0) send(list[k]);
        if (c == 1) cfg_valid = 1'b0;
        tick;
      end
      cur = list[k];
    end
  endtask

  task automatic test_drain;
    cfg_t def = '{31, 16, 0};
    exp_t e;
    int i = 0;
    for (int c = 0; c < 32; c++) q.push_back(dec(c, def, 1'b1));
    for (int c = 0; c < 5; c++)  q.push_back(ZERO_RDY);
    for (int c = 0; c < 32; c++) q.push_back(dec(c, def, 1'b1));
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({cfg_ready, ctrl_hi, ctrl_lo, period_start} !== e) begin
        errors++;
        $display("FAIL drain i=%0d got=%b exp=%b", i, {cfg_ready, ctrl_hi, ctrl_lo, period_start}, e);
      end
      if (i == 9)  en = 1'b0;
      if (i == 35) en = 1'b1;
      i++;
      tick;
    end
  endtask

  task automatic test_reset_mid;
    cfg_t def = '{31, 16, 0};
    cfg_t pend = '{9, 3, 1};
    exp_t e;
    int i = 0;
    for (int c = 0; c < 20; c++) q.push_back(dec(c, def, c <= 1));
    for (int c = 0; c < 3; c++)  q.push_back(ZERO_RDY);
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < 32; c++) q.push_back(dec(c, def, 1'b1));
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({cfg_ready, ctrl_hi, ctrl_lo, period_start} !== e) begin
        errors++;
        $display("FAIL reset_mid i=%0d got=%b exp=%b", i, {cfg_ready, ctrl_hi, ctrl_lo, period_start}, e);
      end
      if (i == 1)  send(pend);
      if (i == 2)  cfg_valid = 1'b0;
      if (i == 19) begin rst = 1'b1; en = 1'b0; end
      if (i == 20) rst = 1'b0;
      if (i == 21) en = 1'b1;
      i++;
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_defaults;
    test_mid_reconfig;
    test_back_to_back;
    test_boundaries;
    test_drain;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_gate_drive.md
# pwm_gate_drive

Upstream gate-drive generator for the switched filter models. It produces a complementary pair of gate signals, `ctrl_hi` and `ctrl_lo`, with programmable period, duty and dead-time. Its reset configuration reproduces the free-running 32-cycle square wave currently derived from a 5-bit counter MSB. New settings arrive over a valid/ready port into a shadow register and take effect only at a period boundary, so the downstream model never sees a truncated or mixed-setting period.

## Interface
- COUNT_BITS, 5, width of period counter and of period/duty fields
- DEAD_BITS, 3, width of dead-time field
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- en  in  1  run request; sampled every cycle
- cfg_valid  in  1  new configuration offered
- cfg_ready  out  1  shadow register empty; transfer when cfg_valid & cfg_ready
- cfg_period  in  COUNT_BITS  P; period length is P+1 cycles
- cfg_duty  in  COUNT_BITS+1  D; raw high phase covers count < D
- cfg_dead  in  DEAD_BITS  dt; dead-time in cycles
- ctrl_hi  out  1  high-side gate (feeds filter `ctrl`)
- ctrl_lo  out  1  low-side gate
- period_start  out  1  one-cycle pulse aligned with the first output cycle of each period

## Operation
- Active registers are P, D and dt. Their reset defaults are P=2^COUNT_BITS-1, D=2^(COUNT_BITS-1) and dt=0.
- Shadow register is loaded on a cfg handshake. `cfg_ready` = !shadow_full.
- Loading the shadow into the active registers:
  - occurs in the cycle where count==P in RUN, or in any IDLE cycle;
  - clears shadow_full;
  - an accept in that same cycle is impossible, because `cfg_ready` is already low.
- FSM states:
  - IDLE: count=0, outputs 0. If en=1, go to RUN; count starts at 0 the next cycle.
  - RUN: count increments, wrapping P→0. If en=0, go to DRAIN.
  - DRAIN: same as RUN. At count==P go to IDLE instead of wrapping. If en returns high in DRAIN, go back to RUN with no gap.
- Output decode, from count c and the active registers. Compare widths are COUNT_BITS+2; there is no overflow.
  - raw = (c < D)
  - hi = raw & (c >= dt)
  - lo = !raw & (c >= D+dt)
  - start = (c==0)
  - In IDLE, hi, lo and start are all 0.
- Invariant: `ctrl_hi & ctrl_lo` is never 1, under any configuration.
- Edge cases:
  - D=0: hi never asserts; lo asserts for c>=dt.
  - D>=P+1: lo never asserts.
  - dt>=D: hi never asserts.
  - P=0: period length is 1; start is high every cycle.
- rst at any time: state IDLE, count 0, active registers to defaults, shadow cleared, all outputs 0.

## Timing
- `ctrl_hi`, `ctrl_lo` and `period_start` are registered. Their value in cycle k+1 is the decode of state and count in cycle k.
- From en rising in IDLE (cycle k):
  - RUN with count=0 in cycle k+1;
  - `period_start` and the first gate values appear in cycle k+2.
- Config latency: settings accepted at any point during a period take effect on the first output cycle of the next period. If accepted in the count==P cycle itself, they take effect one period later.
- In IDLE, an accepted config is active two cycles after the handshake.
- Reset values:
  - `cfg_ready`=1
  - `ctrl_hi`=0
  - `ctrl_lo`=0
  - `period_start`=0

## Test plan
- **Defaults:** rst 2 cycles, then en=1 held.
  - `period_start` every 32 cycles.
  - `ctrl_hi` high for 16 cycles, then `ctrl_lo` high for 16.
  - Never both high.
- **Mid-period reconfiguration:** in RUN at count 5, send P=9, D=3, dt=1.
  - `cfg_ready` drops for the rest of the current period.
  - Next period is 10 cycles: hi at c=1..2, lo at c=4..9.
  - `cfg_ready` returns to 1 after the load.
- **Back-to-back config:** second cfg_valid held during the same period.
  - Stalls with `cfg_ready`=0 until the wrap.
  - Accepted the cycle after the wrap.
  - Applied one period later.
- **Duty/dead-time boundaries:**
  - D=0, dt=2, P=7: hi never; lo at c=2..7.
  - D=8, P=7: lo never; hi at c=0..7.
  - D=3, dt=3: hi never; lo at c=6..7.
- **Drain and re-enable:** en=0 at count 10 of a 32-cycle period.
  - Outputs continue through c=31, then both go 0 and `period_start` stops.
  - en=1 again: first `period_start` two cycles later.
- **Reset mid-run:** rst at count 20 with a shadow config pending.
  - Next cycle: outputs 0, `cfg_ready`=1.
  - After re-enable, default 32-cycle 16/16 waveform; the pending config is discarded.
